camera_capture: RTL and testbench

Captures pixels from an 8-bit parallel camera port (two bytes per RGB565 pixel, high byte first), decimates them and writes them into the camera-side write port of the shared video frame buffer. It produces `write_addr`, `dout_camera` and `mwe_camera` for that port and runs entirely on the camera pixel clock, `clk_write`. It captures whole frames only, flags malformed frames, and pulses once per completed frame.

---
 rtl/camera_pkg.sv | 40 ++++
 rtl/sync_edge.sv | 50 +++++
 rtl/camera_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_camera_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_pkg
// Description : Shared types and helpers for the camera capture block:
//               capture state encoding, RGB565 field layout and the
//               decimation-factor legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // Capture state machine encoding
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,   // waiting for a frame boundary after reset
        ST_ARMED  = 2'd1,   // between frames, waiting for frame start
        ST_ACTIVE = 2'd2,   // capturing lines of the current frame
        ST_DONE   = 2'd3    // one-cycle frame completion pulse
    } cap_state_t;

    // RGB565 field positions within a 16-bit pixel
    localparam int unsigned RGB_R_MSB = 15;
    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_G_MSB = 10;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_B_MSB = 4;
    localparam int unsigned RGB_B_LSB = 0;

    typedef struct packed {
        logic [RGB_R_MSB-RGB_R_LSB:0] r;
        logic [RGB_G_MSB-RGB_G_LSB:0] g;
        logic [RGB_B_MSB-RGB_B_LSB:0] b;
    } rgb565_t;

    // Only power-of-two factors up to 4 are supported; the modulo tests in
    // the capture path are implemented as bit masks.
    function automatic bit decim_legal(input int unsigned d);
        return (d == 1) || (d == 2) || (d == 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Registers a single-bit input once and reports the
//               registered level together with its rising and falling
//               edges (combinational from the registered copy and its
//               one-cycle-delayed history).
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               i_sig   - raw input
//               o_level - registered input
//               o_rise  - registered input went 0 -> 1 this cycle
//               o_fall  - registered input went 1 -> 0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig_q;
    logic r_prev_q;
    logic w_sig_d;
    logic w_prev_d;

    always_comb begin
        w_sig_d  = i_sig;
        w_prev_d = r_sig_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q  <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_sig_q  <= w_sig_d;
            r_prev_q <= w_prev_d;
        end
    end

    assign o_level = r_sig_q;
    assign o_rise  = r_sig_q & ~r_prev_q;
    assign o_fall  = ~r_sig_q & r_prev_q;

endmodule
`default_nettype wire

// File: rtl/camera_capture.sv
`default_nettype none
// ============================================================================
// Module      : camera_capture
// Description : Captures RGB565 pixels (high byte first) from an 8-bit
//               parallel camera port, decimates them in both axes and
//               writes them to the camera-side frame buffer port. Only
//               whole frames are captured; malformed frames are flagged.
// Ports       : clk_write   - camera pixel clock (only clock)
//               reset       - synchronous active-high reset
//               vsync       - frame sync, high between frames
//               href        - line valid
//               cam_data    - camera byte
//               capture_en  - capture enable, sampled at frame start
//               write_addr  - frame buffer write address
//               dout_camera - RGB565 pixel to write
//               mwe_camera  - write strobe, one cycle per pixel
//               frame_done  - one-cycle pulse at end of a captured frame
//               frame_err   - error status of the last captured frame
// Revision    : 1.0 - initial release
// ============================================================================
module camera_capture
    import camera_pkg::*;
#(
    parameter int unsigned H_PIXELS  = 320,
    parameter int unsigned V_LINES   = 240,
    parameter int unsigned DECIM     = 2,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk_write,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic [15:0] write_addr,
    output logic [15:0] dout_camera,
    output logic        mwe_camera,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int unsigned H_OUT = H_PIXELS / DECIM;
    localparam int unsigned V_OUT = V_LINES / DECIM;

    localparam logic [15:0] c_h_pixels   = 16'(H_PIXELS);
    localparam logic [15:0] c_v_lines    = 16'(V_LINES);
    localparam logic [15:0] c_decim_mask = 16'(DECIM - 1);
    localparam logic [15:0] c_base_addr  = 16'(BASE_ADDR);
    localparam logic [16:0] c_frame_px   = 17'(H_OUT * V_OUT);

    generate
        if (!decim_legal(DECIM)) begin : g_decim_illegal
            $error("camera_capture: DECIM must be 1, 2 or 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input registration
    // ------------------------------------------------------------------
    logic w_vsync_lvl;
    logic w_vsync_rise;
    logic w_vsync_fall;
    logic w_href_lvl;
    logic w_href_rise;
    logic w_href_fall;

    sync_edge u_vsync_edge (
        .clk     (clk_write),
        .rst     (reset),
        .i_sig   (vsync),
        .o_level (w_vsync_lvl),
        .o_rise  (w_vsync_rise),
        .o_fall  (w_vsync_fall)
    );

    sync_edge u_href_edge (
        .clk     (clk_write),
        .rst     (reset),
        .i_sig   (href),
        .o_level (w_href_lvl),
        .o_rise  (w_href_rise),
        .o_fall  (w_href_fall)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    cap_state_t  r_state_q,  w_state_d;
    logic [7:0]  r_data_q,   w_data_d;
    logic [7:0]  r_hi_q,     w_hi_d;
    logic        r_phase_q,  w_phase_d;
    logic [15:0] r_col_q,    w_col_d;
    logic [15:0] r_row_q,    w_row_d;
    logic [16:0] r_idx_q,    w_idx_d;
    logic [15:0] r_addr_q,   w_addr_d;
    logic [15:0] r_dout_q,   w_dout_d;
    logic        r_mwe_q,    w_mwe_d;
    logic        r_done_q,   w_done_d;
    logic        r_err_q,    w_err_d;

    logic        w_phase_cur;
    logic        w_decim_hit;
    rgb565_t     w_pixel;

    // A new line always starts on the high byte, whatever the phase was.
    assign w_phase_cur = w_href_rise ? 1'b0 : r_phase_q;

    assign w_decim_hit = ((r_col_q & c_decim_mask) == 16'd0) &&
                         ((r_row_q & c_decim_mask) == 16'd0);

    assign w_pixel = rgb565_t'({r_hi_q, r_data_q});

    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = cam_data;
        w_hi_d    = r_hi_q;
        w_phase_d = r_phase_q;
        w_col_d   = r_col_q;
        w_row_d   = r_row_q;
        w_idx_d   = r_idx_q;
        w_addr_d  = r_addr_q;
        w_dout_d  = r_dout_q;
        w_mwe_d   = 1'b0;
        w_done_d  = 1'b0;
        w_err_d   = r_err_q;

        case (r_state_q)
            ST_SYNC: begin
                // Never join a frame already in progress.
                if (w_vsync_rise) begin
                    w_state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (w_vsync_fall && capture_en) begin
                    w_state_d = ST_ACTIVE;
                    w_col_d   = 16'd0;
                    w_row_d   = 16'd0;
                    w_idx_d   = 17'd0;
                    w_phase_d = 1'b0;
                    w_err_d   = 1'b0;
                end
            end

            ST_ACTIVE: begin
                if (w_vsync_rise) begin
                    // Frame end; a byte or line still in flight is dropped.
                    w_state_d = ST_DONE;
                    w_done_d  = 1'b1;
                    w_phase_d = 1'b0;
                    if ((r_row_q != c_v_lines) || w_href_lvl || r_phase_q) begin
                        w_err_d = 1'b1;
                    end
                end else if (w_href_fall) begin
                    if ((r_col_q != c_h_pixels) || r_phase_q) begin
                        w_err_d = 1'b1;
                    end
                    w_row_d   = (r_row_q == 16'hFFFF) ? r_row_q : r_row_q + 16'd1;
                    w_col_d   = 16'd0;
                    w_phase_d = 1'b0;
                end else if (w_href_lvl) begin
                    if (!w_phase_cur) begin
                        w_hi_d    = r_data_q;
                        w_phase_d = 1'b1;
                    end else begin
                        w_phase_d = 1'b0;
                        w_col_d   = (r_col_q == 16'hFFFF) ? r_col_q : r_col_q + 16'd1;
                        if (r_col_q >= c_h_pixels) begin
                            w_err_d = 1'b1;
                        end else if (w_decim_hit) begin
                            if (r_idx_q < c_frame_px) begin
                                w_mwe_d  = 1'b1;
                                w_addr_d = c_base_addr + r_idx_q[15:0];
                                w_dout_d = w_pixel;
                                w_idx_d  = r_idx_q + 17'd1;
                            end else begin
                                // Buffer full: suppress rather than wrap.
                                w_err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                w_state_d = ST_ARMED;
            end

            default: begin
                w_state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk_write) begin
        if (reset) begin
            r_state_q <= ST_SYNC;
            r_data_q  <= 8'd0;
            r_hi_q    <= 8'd0;
            r_phase_q <= 1'b0;
            r_col_q   <= 16'd0;
            r_row_q   <= 16'd0;
            r_idx_q   <= 17'd0;
            r_addr_q  <= 16'd0;
            r_dout_q  <= 16'd0;
            r_mwe_q   <= 1'b0;
            r_done_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_hi_q    <= w_hi_d;
            r_phase_q <= w_phase_d;
            r_col_q   <= w_col_d;
            r_row_q   <= w_row_d;
            r_idx_q   <= w_idx_d;
            r_addr_q  <= w_addr_d;
            r_dout_q  <= w_dout_d;
            r_mwe_q   <= w_mwe_d;
            r_done_q  <= w_done_d;
            r_err_q   <= w_err_d;
        end
    end

    assign write_addr  = r_addr_q;
    assign dout_camera = r_dout_q;
    assign mwe_camera  = r_mwe_q;
    assign frame_done  = r_done_q;
    assign frame_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_capture
// Description : Directed self-checking bench for camera_capture. Two
//               instances share the stimulus: an 8x4 DECIM=2 build at base
//               0 and an 8x4 DECIM=1 build at base 0xFFFE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_capture;

    logic        clk_write = 1'b0;
    logic        reset     = 1'b1;
    logic        vsync     = 1'b0;
    logic        href      = 1'b0;
    logic [7:0]  cam_data  = 8'd0;
    logic        capture_en = 1'b1;

    logic [15:0] addr1, dout1, addr2, dout2;
    logic        mwe1, done1, err1, mwe2, done2, err2;

    always #5 clk_write = ~clk_write;

    camera_capture #(
        .H_PIXELS (8), .V_LINES (4), .DECIM (2), .BASE_ADDR (0)
    ) u_dut1 (
        .clk_write   (clk_write),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .cam_data    (cam_data),
        .capture_en  (capture_en),
        .write_addr  (addr1),
        .dout_camera (dout1),
        .mwe_camera  (mwe1),
        .frame_done  (done1),
        .frame_err   (err1)
    );

    camera_capture #(
        .H_PIXELS (8), .V_LINES (4), .DECIM (1), .BASE_ADDR (32'hFFFE)
    ) u_dut2 (
        .clk_write   (clk_write),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .cam_data    (cam_data),
        .capture_en  (capture_en),
        .write_addr  (addr2),
        .dout_camera (dout2),
        .mwe_camera  (mwe2),
        .frame_done  (done2),
        .frame_err   (err2)
    );

    // ------------------------------------------------------------------
    // Output monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    logic [15:0] q1_addr[$], q1_data[$], q2_addr[$], q2_data[$];
    int          done_cnt1 = 0, done_cnt2 = 0;
    logic        err_at_done1 = 1'b0, err_at_done2 = 1'b0;
    int          viol1 = 0, viol2 = 0;
    logic        prev_mwe1 = 1'b0, prev_mwe2 = 1'b0;
    int          cyc_cnt = 0, last_w2 = -1000, min_gap2 = 1000;

    always @(posedge clk_write) cyc_cnt++;

    always @(negedge clk_write) begin
        if (mwe1) begin
            q1_addr.push_back(addr1);
            q1_data.push_back(dout1);
            if (prev_mwe1) viol1++;
        end
        prev_mwe1 = mwe1;
        if (done1) begin
            done_cnt1++;
            err_at_done1 = err1;
        end
        if (mwe2) begin
            q2_addr.push_back(addr2);
            q2_data.push_back(dout2);
            if (prev_mwe2) viol2++;
            if (cyc_cnt - last_w2 < min_gap2) min_gap2 = cyc_cnt - last_w2;
            last_w2 = cyc_cnt;
        end
        prev_mwe2 = mwe2;
        if (done2) begin
            done_cnt2++;
            err_at_done2 = err2;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk_write);
        #1;
        vsync    = v;
        href     = h;
        cam_data = d;
    endtask

    // Row r, npix pixels of {hi=r, lo=col}; optional trailing dangling byte.
    task automatic send_line(input int r, input int npix, input bit dangling);
        for (int c = 0; c < npix; c++) begin
            drive(1'b0, 1'b1, 8'(r));
            drive(1'b0, 1'b1, 8'(c));
        end
        if (dangling) drive(1'b0, 1'b1, 8'(r));
        drive(1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic begin_frame();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic end_frame();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'd0);
    endtask

    task automatic clear_q();
        q1_addr.delete(); q1_data.delete();
        q2_addr.delete(); q2_data.delete();
    endtask

    logic [15:0] exp1 [8] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006,
                              16'h0200, 16'h0202, 16'h0204, 16'h0206};
    logic [15:0] exp2_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] exp2_data [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dc;
        int bad;

        // Reset state
        repeat (3) @(posedge clk_write);
        #1;
        check_val("rst_addr", addr1, 0);
        check_val("rst_dout", dout1, 0);
        check_val("rst_mwe",  mwe1,  0);
        check_val("rst_done", done1, 0);
        check_val("rst_err",  err1,  0);
        reset = 1'b0;

        // 1: clean frame
        end_frame();
        clear_q();
        begin_frame();
        for (int r = 0; r < 4; r++) send_line(r, 8, 1'b0);
        end_frame();
        check_val("t1_cnt", q1_addr.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_val("t1_addr", q1_addr[k], k);
            check_val("t1_data", q1_data[k], exp1[k]);
        end
        check_val("t1_done", done_cnt1, 1);
        check_val("t1_err",  err_at_done1, 0);
        check_val("t1_hold_addr", addr1, 16'h0007);
        check_val("t1_hold_dout", dout1, 16'h0206);
        check_val("t1_d2_cnt", q2_addr.size(), 32);
        for (int k = 0; k < 4; k++) begin
            check_val("t1_d2_addr", q2_addr[k], exp2_addr[k]);
            check_val("t1_d2_data", q2_data[k], exp2_data[k]);
        end
        check_val("t1_d2_last_addr", q2_addr[31], 16'h001D);
        check_val("t1_d2_last_data", q2_data[31], 16'h0307);
        check_val("t1_d2_err", err_at_done2, 0);

        // 2: reset inside ACTIVE after three writes
        clear_q();
        dc = done_cnt1;
        begin_frame();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, 8'd0);
            drive(1'b0, 1'b1, 8'(c));
        end
        @(posedge clk_write);
        #1;
        reset = 1'b1;
        href  = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        check_val("t2_pre_cnt", q1_addr.size(), 3);
        check_val("t2_addr", addr1, 0);
        check_val("t2_dout", dout1, 0);
        check_val("t2_mwe",  mwe1,  0);
        check_val("t2_done", done1, 0);
        check_val("t2_err",  err1,  0);
        @(posedge clk_write);
        #1;
        reset = 1'b0;
        clear_q();
        send_line(0, 8, 1'b0);              // no frame boundary seen yet
        check_val("t2_idle_cnt", q1_addr.size(), 0);
        end_frame();
        begin_frame();
        for (int r = 0; r < 4; r++) send_line(r, 8, 1'b0);
        end_frame();
        check_val("t2_done_cnt", done_cnt1, dc + 1);
        check_val("t2_cnt", q1_addr.size(), 8);
        check_val("t2_first_addr", q1_addr[0], 0);
        check_val("t2_last_addr",  q1_addr[7], 7);

        // 3: capture disabled at frame start, raised mid-frame
        clear_q();
        dc = done_cnt1;
        capture_en = 1'b0;
        begin_frame();
        send_line(0, 8, 1'b0);
        send_line(1, 8, 1'b0);
        capture_en = 1'b1;
        send_line(2, 8, 1'b0);
        send_line(3, 8, 1'b0);
        end_frame();
        check_val("t3_cnt",  q1_addr.size(), 0);
        check_val("t3_done", done_cnt1, dc);

        // 4: short line then long line
        clear_q();
        dc = done_cnt1;
        begin_frame();
        send_line(0, 8, 1'b0);
        send_line(1, 6, 1'b0);
        send_line(2, 10, 1'b0);
        send_line(3, 8, 1'b0);
        end_frame();
        bad = 0;
        foreach (q1_data[k]) if (q1_data[k][7:0] >= 8'd8) bad++;
        check_val("t4_cnt", q1_addr.size(), 8);
        check_val("t4_col_ge_h", bad, 0);
        check_val("t4_done", done_cnt1, dc + 1);
        check_val("t4_err",  err_at_done1, 1);
        check_val("t4_err_hold", err1, 1);

        // 5: odd byte count on the first line
        clear_q();
        dc = done_cnt1;
        begin_frame();
        check_val("t5_err_clr", err1, 0);
        send_line(0, 7, 1'b1);
        for (int r = 1; r < 4; r++) send_line(r, 8, 1'b0);
        end_frame();
        check_val("t5_cnt", q1_addr.size(), 8);
        check_val("t5_data3", q1_data[3], 16'h0006);
        check_val("t5_data4", q1_data[4], 16'h0200);
        check_val("t5_done", done_cnt1, dc + 1);
        check_val("t5_err",  err_at_done1, 1);

        // Strobe spacing over the whole run
        check_val("mwe_consec_d1", viol1, 0);
        check_val("mwe_consec_d2", viol2, 0);
        check_val("d2_gap_ge2", (min_gap2 >= 2), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
